// File: rtl/setpoint_ctrl.sv
// Setpoint entry for the RGB heat/cool indicator. Conditions three raw buttons
// and runs an IDLE/EDIT machine that stages a setpoint and commits it with temp_set.
module setpoint_ctrl #(
    parameter int W               = 8,
    parameter int T_MIN           = 50,
    parameter int T_MAX           = 90,
    parameter int T_DEFAULT       = 72,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int EDIT_TIMEOUT    = 500000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_set,
    output logic [W-1:0] desired_temp,
    output logic         temp_set,
    output logic         edit_mode,
    output logic [W-1:0] pending_temp
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = $clog2(RP_MAX + 1);
    localparam int TO_W   = $clog2(EDIT_TIMEOUT + 1);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(EDIT_TIMEOUT - 1);
    localparam logic [W-1:0]    V_MIN      = W'(T_MIN);
    localparam logic [W-1:0]    V_MAX      = W'(T_MAX);
    localparam logic [W-1:0]    V_DEFAULT  = W'(T_DEFAULT);

    // Button index: 0 = up, 1 = down, 2 = set
    logic [2:0]      raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      stable_q, stable_d;
    logic [2:0]      evt_q, evt_d;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];

    logic [RP_W-1:0] rep_cnt_q [2];
    logic [RP_W-1:0] rep_cnt_d [2];
    logic [1:0]      rep_act_q, rep_act_d;
    logic [1:0]      step;

    assign raw = {btn_set, btn_down, btn_up};

    // The stable level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        stable_d = stable_q;
        evt_d    = '0;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                    evt_d[i]    = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // First step on the press, then after REPEAT_DELAY, then every REPEAT_RATE.
    always_comb begin
        rep_act_d = rep_act_q;
        step      = '0;
        for (int i = 0; i < 2; i++) begin
            rep_cnt_d[i] = '0;
            if (evt_q[i]) begin
                step[i]      = 1'b1;
                rep_act_d[i] = 1'b0;
            end else if (!stable_q[i]) begin
                rep_act_d[i] = 1'b0;
            end else if (rep_cnt_q[i] == (rep_act_q[i] ? RATE_LAST : DELAY_LAST)) begin
                step[i]      = 1'b1;
                rep_act_d[i] = 1'b1;
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            evt_q     <= '0;
            rep_act_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
            for (int i = 0; i < 2; i++) rep_cnt_q[i] <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            evt_q     <= evt_d;
            rep_act_q <= rep_act_d;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
            for (int i = 0; i < 2; i++) rep_cnt_q[i] <= rep_cnt_d[i];
        end
    end

    typedef enum logic {S_IDLE, S_EDIT} state_t;

    state_t          state_q;
    logic [W-1:0]    desired_q, pending_q;
    logic            temp_set_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            set_evt, up_only, down_only;

    assign set_evt   = evt_q[2];
    assign up_only   = step[0] & ~step[1];
    assign down_only = step[1] & ~step[0];

    // A set event wins over a same-cycle step, so commit sees the pre-step value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            desired_q  <= V_DEFAULT;
            pending_q  <= V_DEFAULT;
            temp_set_q <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            temp_set_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    to_cnt_q <= '0;
                    if (set_evt) begin
                        state_q   <= S_EDIT;
                        pending_q <= desired_q;
                    end
                end
                S_EDIT: begin
                    if (set_evt) begin
                        desired_q  <= pending_q;
                        temp_set_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else if (|step) begin
                        to_cnt_q <= '0;
                        if (up_only && pending_q < V_MAX)
                            pending_q <= pending_q + 1'b1;
                        else if (down_only && pending_q > V_MIN)
                            pending_q <= pending_q - 1'b1;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q   <= S_IDLE;
                        pending_q <= desired_q;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign desired_temp = desired_q;
    assign pending_temp = pending_q;
    assign temp_set     = temp_set_q;
    assign edit_mode    = (state_q == S_EDIT);

endmodule

// File: tb/tb_setpoint_ctrl.sv
// Bench for setpoint_ctrl: directed scenarios plus random button activity, checked
// every cycle against a timing-level behavioural model of the button/setpoint rules.
module tb_setpoint_ctrl;

    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RR   = 5;
    localparam int TO   = 200;
    localparam int TMIN = 50;
    localparam int TMAX = 90;
    localparam int TDEF = 72;
    localparam int HL   = D + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_set = 1'b0;
    logic [7:0] desired_temp, pending_temp;
    logic       temp_set, edit_mode;

    int checks = 0;
    int failures = 0;

    setpoint_ctrl #(
        .W(8), .T_MIN(TMIN), .T_MAX(TMAX), .T_DEFAULT(TDEF),
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .EDIT_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_set(btn_set),
        .desired_temp(desired_temp), .temp_set(temp_set),
        .edit_mode(edit_mode), .pending_temp(pending_temp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: raw history window for debounce, press age for repeat.
    bit m_hist [3][HL];
    bit m_stable [3];
    bit m_evt [3];
    int m_age [2];
    int m_desired, m_pending, m_idle;
    bit m_edit, m_ts, model_ok;

    always @(posedge clk) begin : model_blk
        bit raw [3];
        bit stp [2];
        bit setev, all_diff;
        raw[0] = btn_up;
        raw[1] = btn_down;
        raw[2] = btn_set;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < HL; j++) m_hist[i][j] = 1'b0;
                m_stable[i] = 1'b0;
                m_evt[i]    = 1'b0;
            end
            m_age[0] = 0;
            m_age[1] = 0;
            m_desired = TDEF;
            m_pending = TDEF;
            m_idle    = 0;
            m_edit    = 1'b0;
            m_ts      = 1'b0;
            model_ok  = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                stp[i] = 1'b0;
                if (m_evt[i]) begin
                    stp[i]   = 1'b1;
                    m_age[i] = 0;
                end else if (m_stable[i]) begin
                    m_age[i]++;
                    if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RR == 0))
                        stp[i] = 1'b1;
                end
            end
            setev = m_evt[2];
            m_ts  = 1'b0;
            if (!m_edit) begin
                if (setev) begin
                    m_edit    = 1'b1;
                    m_pending = m_desired;
                    m_idle    = 0;
                end
            end else if (setev) begin
                m_desired = m_pending;
                m_ts      = 1'b1;
                m_edit    = 1'b0;
            end else if (stp[0] || stp[1]) begin
                m_idle = 0;
                if (stp[0] && !stp[1]) m_pending = (m_pending + 1 > TMAX) ? TMAX : m_pending + 1;
                if (stp[1] && !stp[0]) m_pending = (m_pending - 1 < TMIN) ? TMIN : m_pending - 1;
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_edit    = 1'b0;
                    m_pending = m_desired;
                end
            end
            // Sample k-2 .. k-D-1 is what has passed through the two sync stages.
            for (int i = 0; i < 3; i++) begin
                for (int j = HL - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
                m_hist[i][0] = raw[i];
                all_diff = 1'b1;
                for (int j = 2; j < HL; j++)
                    if (m_hist[i][j] == m_stable[i]) all_diff = 1'b0;
                m_evt[i] = 1'b0;
                if (all_diff) begin
                    m_stable[i] = ~m_stable[i];
                    m_evt[i]    = m_stable[i];
                end
            end
        end
    end

    int ts_count = 0;
    int edit_rises = 0;
    bit prev_ts = 1'b0;
    bit prev_edit = 1'b0;

    always @(negedge clk) begin
        if (model_ok) begin
            chk("desired_temp", int'(desired_temp), m_desired);
            chk("pending_temp", int'(pending_temp), m_pending);
            chk("edit_mode", int'(edit_mode), int'(m_edit));
            chk("temp_set", int'(temp_set), int'(m_ts));
            chk("temp_set_double", int'(temp_set & prev_ts), 0);
        end
        if (temp_set) ts_count++;
        if (edit_mode && !prev_edit) edit_rises++;
        prev_ts   = temp_set;
        prev_edit = edit_mode;
    end

    task automatic drive(input logic u, input logic d, input logic s, input int cycles);
        btn_up   = u;
        btn_down = d;
        btn_set  = s;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic press(input logic u, input logic d, input logic s, input int hold);
        drive(u, d, s, hold);
        drive(1'b0, 1'b0, 1'b0, 10);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_desired"}, int'(desired_temp), TDEF);
        chk({tag, "_pending"}, int'(pending_temp), TDEF);
        chk({tag, "_temp_set"}, int'(temp_set), 0);
        chk({tag, "_edit"}, int'(edit_mode), 0);
    endtask

    task automatic wait_edit_low(input int budget);
        int n;
        n = 0;
        while (edit_mode && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("edit_exit_within_budget", int'(edit_mode), 0);
    endtask

    initial begin
        int ts0, er0, r, hold;
        @(negedge clk);
        do_reset();
        check_reset_vals("reset");

        // Bounced set press produces exactly one event.
        er0 = edit_rises;
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 1'b0, 10);
        chk("bounce_edit_mode", int'(edit_mode), 1);
        chk("bounce_one_event", edit_rises - er0, 1);

        // Three clean up presses, then commit.
        repeat (3) press(1'b1, 1'b0, 1'b0, 8);
        chk("three_up_pending", int'(pending_temp), 75);
        ts0 = ts_count;
        press(1'b0, 1'b0, 1'b1, 8);
        chk("commit_desired", int'(desired_temp), 75);
        chk("commit_one_pulse", ts_count - ts0, 1);
        chk("commit_edit_off", int'(edit_mode), 0);

        // Climb to 88, then hold up into saturation.
        press(1'b0, 1'b0, 1'b1, 8);
        repeat (13) press(1'b1, 1'b0, 1'b0, 8);
        chk("climb_pending", int'(pending_temp), 88);
        drive(1'b1, 1'b0, 1'b0, 40);
        drive(1'b0, 1'b0, 1'b0, 10);
        chk("hold_saturated", int'(pending_temp), 90);
        ts0 = ts_count;
        wait_edit_low(400);
        chk("hold_timeout_pending", int'(pending_temp), 75);
        chk("hold_timeout_desired", int'(desired_temp), 75);
        chk("hold_timeout_no_pulse", ts_count - ts0, 0);

        // One down press, then abandon by timeout.
        do_reset();
        check_reset_vals("reset2");
        press(1'b0, 1'b0, 1'b1, 8);
        press(1'b0, 1'b1, 1'b0, 8);
        chk("down_pending", int'(pending_temp), 71);
        ts0 = ts_count;
        wait_edit_low(400);
        chk("timeout_pending", int'(pending_temp), 72);
        chk("timeout_desired", int'(desired_temp), 72);
        chk("timeout_no_pulse", ts_count - ts0, 0);

        // Simultaneous up/down is dropped; reset mid-edit discards the edit.
        do_reset();
        press(1'b0, 1'b0, 1'b1, 8);
        press(1'b1, 1'b1, 1'b0, 8);
        chk("both_pending", int'(pending_temp), 72);
        press(1'b1, 1'b0, 1'b0, 8);
        chk("after_both_up", int'(pending_temp), 73);
        do_reset();
        check_reset_vals("mid_edit_reset");

        // Random button activity against the model.
        for (int seg = 0; seg < 250; seg++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                reset = 1'b1;
                drive(1'b0, 1'b0, 1'b0, $urandom_range(1, 2));
                reset = 1'b0;
            end else if (r < 3) begin
                drive(1'b0, 1'b0, 1'b0, $urandom_range(20, 230));
            end else begin
                hold = ($urandom_range(0, 4) == 0) ? $urandom_range(15, 45) : $urandom_range(1, 12);
                drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 3) == 0, hold);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
